// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
//   state_e        : occupancy of a two-entry skid stage (EMPTY / ONE / FULL)
//   PAYLOAD_W_DEF  : default fetch-to-decode payload width
//   *_LSB / *_W    : field placement inside the fetch-to-decode payload
//                    {instr[96:65], pcplus4[64:33], pc[32:1], branchfound[0]}
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int PAYLOAD_W_DEF = 97;

  localparam int INSTR_LSB   = 65;
  localparam int INSTR_W     = 32;
  localparam int PCPLUS4_LSB = 33;
  localparam int PCPLUS4_W   = 32;
  localparam int PC_LSB      = 1;
  localparam int PC_W        = 32;
  localparam int BRFOUND_BIT = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter used for predictor statistics.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high, clears cnt
//   inc   : count one event this cycle (ignored once cnt is all-ones)
//   clr   : synchronous clear, wins over inc
//   cnt   : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer.
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   flush      : synchronous kill of all held entries
//   stat_clr   : synchronous clear of stall_cnt
//   up_valid / up_ready / up_data : upstream side
//   dn_valid / dn_ready / dn_data : downstream side
//   stall_cnt  : saturating count of cycles with dn_valid=1 and dn_ready=0
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// up_ready and dn_valid are flops, so neither side ever sees a combinational
// path from the other; the skid entry catches the one beat that upstream may
// send in the cycle before up_ready falls.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 stat_clr,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [PAYLOAD_W-1:0] dn_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 up_fire, dn_fire;

  assign up_fire = up_valid & up_ready;
  assign dn_fire = dn_valid & dn_ready;

  // Empty slots are always written back to zero so dn_data reads 0 when idle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_fire) begin
            state_d = ST_ONE;
            main_d  = up_data;
          end
        end
        ST_ONE: begin
          if (up_fire && dn_fire) begin
            main_d = up_data;
          end else if (up_fire) begin
            state_d = ST_FULL;
            skid_d  = up_data;
          end else if (dn_fire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          if (dn_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the next state and registered so
  // they are pure flop outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      up_ready <= 1'b1;
      dn_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      up_ready <= (state_d != ST_FULL);
      dn_valid <= (state_d != ST_EMPTY);
    end
  end

  assign dn_data = main_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dn_valid & ~dn_ready),
    .clr   (stat_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int PW = PAYLOAD_W_DEF;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          stat_clr;
  logic          up_valid;
  logic          up_ready;
  logic [PW-1:0] up_data;
  logic          dn_valid;
  logic          dn_ready;
  logic [PW-1:0] dn_data;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_skid_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stat_clr  (stat_clr),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready),
    .dn_data   (dn_data),
    .stall_cnt (stall_cnt)
  );

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] make_beat(input logic [31:0] instr, input logic [31:0] pc,
                                              input logic br);
    logic [PW-1:0] b;
    b = '0;
    b[INSTR_LSB +: INSTR_W]     = instr;
    b[PCPLUS4_LSB +: PCPLUS4_W] = pc + 32'd4;
    b[PC_LSB +: PC_W]           = pc;
    b[BRFOUND_BIT]              = br;
    return b;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_up_ready"}, PW'(up_ready), 1);
    chk({tag, "_dn_valid"}, PW'(dn_valid), 0);
    chk({tag, "_dn_data"}, dn_data, '0);
    chk({tag, "_stall_cnt"}, PW'(stall_cnt), 0);
  endtask

  // ---------------- scoreboard ----------------
  // Accepted beats are queued; each downstream transfer pops and compares.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (dn_valid && dn_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_beat", PW'(exp_q.size()), 1);
        else chk("sb_data", dn_data, exp_q.pop_front());
      end
      if (!dn_valid) chk("sb_idle_zero", dn_data, '0);
      if (flush) exp_q.delete();
      else if (up_valid && up_ready) exp_q.push_back(up_data);
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [PW-1:0] a, b, c, x;
    logic          ur;

    reset = 1'b1; flush = 1'b0; stat_clr = 1'b0;
    up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
    #12;
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Back-to-back beats with downstream always ready.
    dn_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up_valid = 1'b1;
      up_data  = PW'(i);
      step();
      chk("b2b_data", dn_data, PW'(i));
      chk("b2b_valid", PW'(dn_valid), 1);
      chk("b2b_up_ready", PW'(up_ready), 1);
    end
    up_valid = 1'b0;
    step();
    chk("b2b_drained", PW'(dn_valid), 0);
    chk("b2b_stall", PW'(stall_cnt), 0);

    // Stall with skid fill: A shown, B into skid, C held upstream.
    a = make_beat(32'h0000_0013, 32'h0000_1000, 1'b0);
    b = make_beat(32'h0040_006F, 32'h0000_1004, 1'b1);
    c = make_beat(32'hFE00_0EE3, 32'h0000_1008, 1'b0);
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = a;
    step();
    chk("skid_a_shown", dn_data, a);
    up_data = b;
    step();
    chk("skid_full_up_ready", PW'(up_ready), 0);
    up_data = c;
    step();
    step();
    chk("skid_hold_a", dn_data, a);
    chk("skid_c_held", PW'(up_ready), 0);
    chk("skid_stall3", PW'(stall_cnt), 3);
    dn_ready = 1'b1;
    step();
    chk("skid_rel_b", dn_data, b);
    chk("skid_rel_up_ready", PW'(up_ready), 1);
    step();
    chk("skid_rel_c", dn_data, c);
    up_valid = 1'b0;
    step();
    chk("skid_rel_empty", PW'(dn_valid), 0);
    chk("skid_stall_kept", PW'(stall_cnt), 3);

    // Flush while FULL with a same-cycle offered beat 0xD.
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = PW'(32'h11);
    step();
    up_data = PW'(32'h22);
    step();
    chk("flush_pre_full", PW'(up_ready), 0);
    flush = 1'b1; up_data = PW'(32'hD);
    step();
    flush = 1'b0; up_valid = 1'b0;
    chk("flush_valid", PW'(dn_valid), 0);
    chk("flush_data", dn_data, '0);
    chk("flush_up_ready", PW'(up_ready), 1);
    dn_ready = 1'b1;
    step();
    chk("flush_no_d", PW'(dn_valid), 0);

    // Saturation of the 4-bit stall counter and clear priority.
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("sat_cleared", PW'(stall_cnt), 0);
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = PW'(32'h77);
    step();
    up_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_15", PW'(stall_cnt), 15);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("sat_clr_wins", PW'(stall_cnt), 0);
    step();
    chk("sat_recount", PW'(stall_cnt), 1);
    dn_ready = 1'b1;
    step();
    chk("sat_drained", PW'(dn_valid), 0);

    // Asynchronous reset while FULL, then 1-cycle latency afterwards.
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = PW'(32'h31);
    step();
    up_data = PW'(32'h32);
    step();
    up_valid = 1'b0;
    chk("areset_pre_full", PW'(up_ready), 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("areset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    dn_ready = 1'b1;
    x = make_beat(32'hDEAD_BEEF, 32'h0000_2000, 1'b1);
    up_valid = 1'b1; up_data = x;
    step();
    chk("areset_first_data", dn_data, x);
    chk("areset_first_valid", PW'(dn_valid), 1);
    up_valid = 1'b0;
    step();
    chk("areset_drained", PW'(dn_valid), 0);

    // Random traffic; up_ready must not move when dn_ready moves.
    for (int i = 0; i < 10000; i++) begin
      up_valid = 1'($urandom_range(0, 1));
      up_data  = make_beat($urandom, $urandom, 1'($urandom_range(0, 1)));
      step();
      ur = up_ready;
      dn_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rand_up_ready_comb", PW'(up_ready), PW'(ur));
    end
    up_valid = 1'b0;
    dn_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("rand_drain_queue", PW'(exp_q.size()), 0);
    chk("rand_drain_valid", PW'(dn_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It replaces fixed-field enable/clear stage registers such as the fetch-to-decode register, so upstream can stall without a combinational path from downstream ready. It supports synchronous flush on branch mispredict and keeps a saturating backpressure counter for predictor performance analysis.

## Interface
- PAYLOAD_W, 97, payload width (instr 32 + pcplus4 32 + pc 32 + branchfound 1)
- CNT_W, 16, stall counter width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all held entries (mispredict / redirect)
- stat_clr  in  1  synchronous clear of stall_cnt
- up_valid  in  1  upstream payload valid
- up_ready  out  1  stage can accept; registered, no combinational input dependency
- up_data  in  PAYLOAD_W  upstream payload
- dn_valid  out  1  main entry holds a valid payload
- dn_ready  in  1  downstream accepts this cycle
- dn_data  out  PAYLOAD_W  main-entry payload
- stall_cnt  out  CNT_W  cycles with dn_valid=1 and dn_ready=0, saturating

## Operation
- up_fire = up_valid & up_ready; dn_fire = dn_valid & dn_ready.
- Storage: main register (drives dn_data) and skid register; state EMPTY / ONE / FULL.
- up_ready = 1 in EMPTY and ONE, 0 in FULL. dn_valid = 1 in ONE and FULL.
- EMPTY: up_fire -> ONE, main <= up_data.
- ONE: up_fire & dn_fire -> ONE, main <= up_data; up_fire & !dn_fire -> FULL, skid <= up_data; !up_fire & dn_fire -> EMPTY, main <= 0; otherwise hold.
- FULL: dn_fire -> ONE, main <= skid, skid <= 0; otherwise hold. up_valid is ignored.
- Payload is preserved in order; no payload is duplicated or dropped except on flush.
- Flush has priority over every other event in the same cycle. Next state is EMPTY, main and skid are zeroed, and a same-cycle up_fire is discarded. dn_fire in a flush cycle is still a completed transfer for downstream.
- stall_cnt increments when dn_valid & !dn_ready and saturates at 2^CNT_W-1. stat_clr forces 0 and wins over a same-cycle increment. flush does not affect stall_cnt.
- Invalid entries always read as all-zero, so dn_data = 0 when dn_valid = 0.

## Timing
- Reset values: state EMPTY, main = 0, skid = 0, dn_valid = 0, dn_data = 0, up_ready = 1, stall_cnt = 0.
- Reset asserted mid-operation discards all entries immediately and asynchronously.
- Latency: payload accepted at edge N appears on dn_data/dn_valid after edge N, i.e. 1 cycle.
- Throughput: 1 per cycle sustained while dn_ready = 1.
- up_ready deasserts the cycle after the skid fills. The skid absorbs the one in-flight beat accepted while downstream stalled.
- up_ready and dn_valid are pure register outputs. There is no combinational path from any input to any output except none: dn_data, dn_valid and up_ready are all flop-driven.

## Structure
- Shared package pipe_pkg:
  - state enum (EMPTY, ONE, FULL)
  - payload field offsets/widths: INSTR_LSB = 65, PCPLUS4_LSB = 33, PC_LSB = 1, BRFOUND_BIT = 0
  - default PAYLOAD_W constant
- Sub-module sat_counter (parameter W; inputs inc, clr; output cnt) implements stall_cnt. It is reused by other predictor statistics.

## Test plan
- Reset then 4 back-to-back beats 0x1..0x4 with dn_ready = 1 -> dn_data = 0x1..0x4 on consecutive cycles, up_ready constantly 1, stall_cnt = 0.
- Beats A, B, C offered; dn_ready low for 3 cycles after A is shown:
  - A is held on dn_data and B fills the skid.
  - up_ready drops and C is held upstream.
  - On release, dn_data sequence is A, B, C.
  - stall_cnt = 3.
- FULL state with flush = 1 and up_valid = 1 (data 0xD) in the same cycle -> next cycle dn_valid = 0, dn_data = 0, up_ready = 1, 0xD never appears.
- CNT_W = 4, dn_ready held low for 20 cycles with dn_valid = 1 -> stall_cnt saturates at 15. stat_clr together with a stall cycle -> stall_cnt = 0.
- Reset asserted between edges while FULL -> outputs immediately at reset values with no clock edge needed. After release, the first new beat emerges with 1-cycle latency.
- Random up_valid/dn_ready (10k cycles, no flush) -> scoreboard shows in-order, loss-free delivery. up_ready never depends combinationally on dn_ready.
